rt_uart_tx_arb: RTL and testbench
=================================

# rt_uart_tx_arb

Round-robin arbiter sharing the single RT-subsystem UART transmitter between several byte-stream requesters (Ibex debug print, DMA log channel, test-harness injector). It sits between the requesters and the UART TX FIFO write port. Grants are packet-atomic: an owner keeps the grant until it marks its last byte or hits a hold limit. A registered one-entry output stage keeps the path to the UART timing-clean.

## Interface
- NumReq, 4: number of requesters, 2..8.
- MaxHold, 64: maximum bytes per grant before a forced release, 1..255.
- TimeoutCycles, 1024: idle-owner cycles before a forced release. Only used when the timeout feature is compiled in.

- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous reset, active-high.
- req_valid_i  in  NumReq  requester has a byte.
- req_data_i  in  NumReq*8  byte of requester k at [8k+7:8k].
- req_last_i  in  NumReq  byte is the last byte of the packet.
- req_ready_o  out  NumReq  byte accepted when valid and ready are both high.
- tx_valid_o  out  1  byte valid toward the UART.
- tx_data_o  out  8  byte toward the UART.
- tx_ready_i  in  1  UART accepts the byte.
- grant_o  out  NumReq  one-hot current owner, or all zero.
- busy_o  out  1  a grant is held or the output stage is full.
- timeout_o  out  1  one-cycle pulse on a forced timeout release.

## Operation
- FSM states: IDLE, XFER.
- IDLE
  - If any req_valid_i is high, the round-robin pick starts searching at ptr. The winner is registered into grant_o and the FSM moves to XFER.
  - If no req_valid_i is high, the FSM stays in IDLE.
- XFER
  - req_ready_o[g] = grant_o[g] & (~tx_valid_o | tx_ready_i). All other ready bits are 0.
  - An accepted byte is loaded into tx_data_o and tx_valid_o is set. hold_cnt increments.
  - Release happens on an accepted byte with req_last_i set, or when hold_cnt reaches MaxHold.
  - On release: grant_o is cleared, ptr = (g+1) mod NumReq, hold_cnt = 0, FSM goes to IDLE.
- Output stage
  - tx_valid_o clears when tx_ready_i is high and no new byte is accepted in the same cycle.
  - tx_data_o is stable while tx_valid_o & ~tx_ready_i.
- Widths
  - ptr is $clog2(NumReq) bits and wraps from NumReq-1 to 0.
  - hold_cnt is 8 bits and saturates at MaxHold.
- Boundaries
  - Release and new requests in the same cycle: the next grant is decided in IDLE on the following cycle. This gives a fixed one-cycle bubble.
  - The last byte is accepted while the output stage is still draining: the release happens anyway, and the buffered byte still completes.
  - A requester dropping valid mid-packet keeps its grant.
  - Reset mid-operation: the buffered byte is discarded with no partial emission.
- Reset values: tx_valid_o=0, tx_data_o=0, grant_o=0, req_ready_o=0, busy_o=0, timeout_o=0, ptr=0, state=IDLE.

## Timing
- req_valid_i rises in IDLE at cycle N: grant_o and req_ready_o at N+1, byte accepted at N+1, tx_valid_o at N+2.
- Sustained throughput is one byte per cycle when tx_ready_i is held high.
- Minimum gap between packets from different owners is 2 cycles: the release cycle plus the IDLE decision cycle.
- No combinational path from req_valid_i to tx_valid_o. The only combinational input-to-output path is tx_ready_i to req_ready_o.

## Configuration
- RT_UART_ARB_TIMEOUT_EN defined:
  - A counter increments each XFER cycle with ~req_valid_i[g] and resets on any accepted byte.
  - At TimeoutCycles: forced release, timeout_o pulses 1 cycle, ptr advances.
  - Counter width is $clog2(TimeoutCycles+1).
- RT_UART_ARB_TIMEOUT_EN undefined: no counter, timeout_o tied 0. A stalled owner holds the grant indefinitely.

## Structure
- rt_uart_arb_pkg: arb_state_e {IDLE, XFER}, byte_t (logic [7:0]), DefaultMaxHold and DefaultTimeout constants.
- Sub-module rt_rr_pick: combinational one-hot round-robin selection from req and ptr, NumReq parameter.
- Top holds the FSM, counters and output stage.

## Test plan
- Single packet: req 1 sends 0x41,0x42,0x43(last) with tx_ready_i=1 -> tx_data_o shows 0x41..0x43 on consecutive cycles starting N+2; grant_o returns to 0 and ptr becomes 2.
- Fairness: all 4 requesters send 1-byte packets continuously -> grant order 0,1,2,3,0, each separated by a 1-cycle bubble.
- Hold limit: MaxHold=4, req 2 streams 10 bytes with no last -> grant released after the 4th byte; req 3 (also pending) is served next.
- Backpressure: tx_ready_i low for 5 cycles mid-packet -> tx_data_o held stable, req_ready_o=0, no byte lost or duplicated.
- Timeout (macro on, TimeoutCycles=16): owner drops valid mid-packet -> timeout_o pulses at cycle 16; grant moves to the next pending requester. With the macro off, the grant is held.
- Reset mid-transfer: assert rst_i while tx_valid_o=1 -> all outputs 0 in the same cycle; the first grant after reset goes to requester 0.

Source files
------------

// File: rtl/rt_uart_arb_pkg.sv
// Shared types and defaults for the RT-subsystem UART transmit arbiter.
package rt_uart_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  typedef logic [7:0] byte_t;

  localparam int unsigned DefaultMaxHold = 64;
  localparam int unsigned DefaultTimeout = 1024;

endpackage

// File: rtl/rt_rr_pick.sv
// Combinational round-robin picker: one-hot winner, searching upward from ptr_i with wrap.
module rt_rr_pick #(
  parameter int unsigned NumReq = 4
) (
  input  logic [NumReq-1:0]         req_i,
  input  logic [$clog2(NumReq)-1:0] ptr_i,
  output logic [NumReq-1:0]         gnt_o
);

  localparam int unsigned PtrW = $clog2(NumReq);

  logic            found;
  logic [PtrW-1:0] idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      idx = PtrW'((32'(ptr_i) + i) % NumReq);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rt_uart_tx_arb.sv
// Packet-atomic round-robin arbiter in front of the UART TX FIFO, with a one-entry output stage.
// Optional idle-owner timeout release is compiled in with RT_UART_ARB_TIMEOUT_EN.
module rt_uart_tx_arb
  import rt_uart_arb_pkg::*;
#(
  parameter int unsigned NumReq        = 4,
  parameter int unsigned MaxHold       = DefaultMaxHold,
  parameter int unsigned TimeoutCycles = DefaultTimeout
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumReq-1:0]   req_valid_i,
  input  logic [NumReq*8-1:0] req_data_i,
  input  logic [NumReq-1:0]   req_last_i,
  output logic [NumReq-1:0]   req_ready_o,
  output logic                tx_valid_o,
  output logic [7:0]          tx_data_o,
  input  logic                tx_ready_i,
  output logic [NumReq-1:0]   grant_o,
  output logic                busy_o,
  output logic                timeout_o
);

  localparam int unsigned PtrW = $clog2(NumReq);

  arb_state_e        state_q;
  logic [NumReq-1:0] grant_q;
  logic [PtrW-1:0]   owner_q;
  logic [PtrW-1:0]   ptr_q;
  logic [7:0]        hold_q;
  logic              tx_valid_q;
  byte_t             tx_data_q;

  logic [NumReq-1:0] pick;
  logic [PtrW-1:0]   pick_idx;
  logic [PtrW-1:0]   ptr_nxt;
  logic              stage_free;
  logic              accept;
  logic              valid_own;
  logic              last_own;
  logic              hold_hit;
  logic              to_fire;
  logic              release_now;
  byte_t             data_own;

  rt_rr_pick #(
    .NumReq(NumReq)
  ) u_pick (
    .req_i(req_valid_i),
    .ptr_i(ptr_q),
    .gnt_o(pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (pick[i]) pick_idx = PtrW'(i);
    end
  end

  // The only combinational input-to-output path: tx_ready_i frees the stage for the owner.
  assign stage_free  = ~tx_valid_q | tx_ready_i;
  assign req_ready_o = grant_q & {NumReq{stage_free}};
  assign accept      = |(req_valid_i & req_ready_o);

  assign valid_own   = req_valid_i[owner_q];
  assign last_own    = req_last_i[owner_q];
  assign data_own    = req_data_i[32'(owner_q) * 8 +: 8];
  assign hold_hit    = (hold_q == 8'(MaxHold - 1));
  assign release_now = (accept && (last_own || hold_hit)) || to_fire;
  assign ptr_nxt     = (owner_q == PtrW'(NumReq - 1)) ? '0 : owner_q + PtrW'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      ptr_q      <= '0;
      hold_q     <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      if (accept) begin
        tx_data_q  <= data_own;
        tx_valid_q <= 1'b1;
      end else if (tx_ready_i) begin
        tx_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (|req_valid_i) begin
            grant_q <= pick;
            owner_q <= pick_idx;
            hold_q  <= '0;
            state_q <= XFER;
          end
        end
        XFER: begin
          if (accept && hold_q != 8'(MaxHold)) hold_q <= hold_q + 8'd1;
          if (release_now) begin
            grant_q <= '0;
            ptr_q   <= ptr_nxt;
            hold_q  <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef RT_UART_ARB_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TimeoutCycles + 1);

  logic [ToW-1:0] to_cnt_q;
  logic           timeout_q;

  // Count only cycles where the owner has nothing to offer; any accepted byte restarts it.
  assign to_fire = (state_q == XFER) && !accept && !valid_own &&
                   (to_cnt_q == ToW'(TimeoutCycles - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= to_fire;
      if (state_q != XFER || accept || to_fire) begin
        to_cnt_q <= '0;
      end else if (!valid_own) begin
        to_cnt_q <= to_cnt_q + ToW'(1);
      end
    end
  end

  assign timeout_o = timeout_q;
`else
  logic unused_timeout;

  assign to_fire        = 1'b0;
  assign unused_timeout = (TimeoutCycles != 0);
  assign timeout_o      = 1'b0;
`endif

  assign grant_o    = grant_q;
  assign tx_valid_o = tx_valid_q;
  assign tx_data_o  = tx_data_q;
  assign busy_o     = (state_q == XFER) | tx_valid_q;

endmodule

// File: tb/tb_rt_uart_tx_arb.sv
// Directed self-checking bench for rt_uart_tx_arb (NumReq=4, MaxHold=4, TimeoutCycles=16).
module tb_rt_uart_tx_arb;

  localparam int unsigned N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           tx_valid;
  logic [7:0]     tx_data;
  logic           tx_ready;
  logic [N-1:0]   grant;
  logic           busy;
  logic           timeout;

  int checks   = 0;
  int failures = 0;

  int order [5] = '{2, 3, 0, 1, 2};

  always #5 clk = ~clk;

  rt_uart_tx_arb #(
    .NumReq(N),
    .MaxHold(4),
    .TimeoutCycles(16)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .req_valid_i(req_valid),
    .req_data_i(req_data),
    .req_last_i(req_last),
    .req_ready_o(req_ready),
    .tx_valid_o(tx_valid),
    .tx_data_o(tx_data),
    .tx_ready_i(tx_ready),
    .grant_o(grant),
    .busy_o(busy),
    .timeout_o(timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic edge_in();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_req(input int k, input logic v, input logic [7:0] d, input logic l);
    req_valid[k]         = v;
    req_data[k*8 +: 8]   = d;
    req_last[k]          = l;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_ready  = 1'b1;

    // Reset state
    repeat (2) sample();
    check("rst_tx_valid", 32'(tx_valid), 0);
    check("rst_tx_data",  32'(tx_data),  0);
    check("rst_grant",    32'(grant),    0);
    check("rst_ready",    32'(req_ready), 0);
    check("rst_busy",     32'(busy),     0);
    check("rst_timeout",  32'(timeout),  0);
    edge_in();
    rst = 1'b0;

    // Single packet from requester 1: 0x41, 0x42, 0x43(last)
    edge_in(); set_req(1, 1'b1, 8'h41, 1'b0);
    sample();  check("sp_n_grant", 32'(grant), 0);
    edge_in();
    sample();  check("sp_grant", 32'(grant), 32'h2);
               check("sp_ready", 32'(req_ready), 32'h2);
               check("sp_n1_txv", 32'(tx_valid), 0);
    edge_in(); set_req(1, 1'b1, 8'h42, 1'b0);
    sample();  check("sp_n2_txv", 32'(tx_valid), 1);
               check("sp_n2_data", 32'(tx_data), 32'h41);
    edge_in(); set_req(1, 1'b1, 8'h43, 1'b1);
    sample();  check("sp_n3_data", 32'(tx_data), 32'h42);
    edge_in(); set_req(1, 1'b0, 8'h00, 1'b0);
    sample();  check("sp_n4_data", 32'(tx_data), 32'h43);
               check("sp_n4_grant", 32'(grant), 0);
               check("sp_n4_busy", 32'(busy), 1);
    edge_in();
    sample();  check("sp_n5_txv", 32'(tx_valid), 0);
               check("sp_n5_busy", 32'(busy), 0);

    // Fairness: all requesters hold 1-byte packets; ptr is 2 after the packet above
    edge_in();
    for (int k = 0; k < int'(N); k++) set_req(k, 1'b1, 8'hA0 + 8'(k), 1'b1);
    for (int i = 0; i < 5; i++) begin
      edge_in();
      sample();
      check("fair_grant", 32'(grant), 32'(1) << order[i]);
      check("fair_ready", 32'(req_ready), 32'(1) << order[i]);
      edge_in();
      if (i == 4) req_valid = '0;
      sample();
      check("fair_bubble", 32'(grant), 0);
      check("fair_data", 32'(tx_data), 32'hA0 + 32'(order[i]));
    end

    // Hold limit: requester 2 streams without last, requester 3 pending; ptr is 3
    edge_in(); set_req(2, 1'b1, 8'h10, 1'b0);
    edge_in(); set_req(3, 1'b1, 8'h77, 1'b1);
    sample();  check("hold_c1_grant", 32'(grant), 32'h4);
    for (int c = 2; c <= 4; c++) begin
      edge_in(); req_data[23:16] = 8'h10 + 8'(c - 1);
      sample();
      check("hold_grant", 32'(grant), 32'h4);
      check("hold_data", 32'(tx_data), 32'h10 + 32'(c - 2));
    end
    edge_in(); req_data[23:16] = 8'h14;
    sample();  check("hold_rel_grant", 32'(grant), 0);
               check("hold_rel_ready", 32'(req_ready), 0);
               check("hold_rel_data", 32'(tx_data), 32'h13);
    edge_in();
    sample();  check("hold_next_grant", 32'(grant), 32'h8);
               check("hold_next_ready", 32'(req_ready), 32'h8);
               check("hold_next_txv", 32'(tx_valid), 0);
    edge_in(); req_valid = '0; req_last = '0;
    sample();  check("hold_r3_data", 32'(tx_data), 32'h77);
               check("hold_r3_grant", 32'(grant), 0);

    // Backpressure: requester 0 (ptr 0), tx_ready low for 5 cycles mid-packet
    edge_in(); set_req(0, 1'b1, 8'h50, 1'b0);
    edge_in();
    sample();  check("bp_grant", 32'(grant), 32'h1);
    edge_in(); set_req(0, 1'b1, 8'h51, 1'b0); tx_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c != 0) edge_in();
      sample();
      check("bp_stall_data", 32'(tx_data), 32'h50);
      check("bp_stall_txv", 32'(tx_valid), 1);
      check("bp_stall_ready", 32'(req_ready), 0);
    end
    edge_in(); tx_ready = 1'b1;
    sample();  check("bp_resume_ready", 32'(req_ready), 32'h1);
               check("bp_resume_data", 32'(tx_data), 32'h50);
    edge_in(); set_req(0, 1'b1, 8'h52, 1'b1);
    sample();  check("bp_b1_data", 32'(tx_data), 32'h51);
    edge_in(); set_req(0, 1'b0, 8'h00, 1'b0);
    sample();  check("bp_b2_data", 32'(tx_data), 32'h52);
               check("bp_b2_grant", 32'(grant), 0);
    edge_in();
    sample();  check("bp_drain_txv", 32'(tx_valid), 0);

    // Stalled owner: requester 1 (ptr 1) drops valid mid-packet, requester 3 pending
    edge_in(); set_req(1, 1'b1, 8'h61, 1'b0);
    edge_in();
    sample();  check("to_grant", 32'(grant), 32'h2);
    edge_in(); set_req(1, 1'b0, 8'h61, 1'b0); set_req(3, 1'b1, 8'h33, 1'b1);
    sample();  check("to_data", 32'(tx_data), 32'h61);
    for (int c = 3; c <= 17; c++) begin
      edge_in();
      sample();
      check("to_hold_grant", 32'(grant), 32'h2);
      check("to_hold_pulse", 32'(timeout), 0);
    end
`ifdef RT_UART_ARB_TIMEOUT_EN
    edge_in();
    sample();  check("to_fire_pulse", 32'(timeout), 1);
               check("to_fire_grant", 32'(grant), 0);
    edge_in();
    sample();  check("to_after_pulse", 32'(timeout), 0);
               check("to_next_grant", 32'(grant), 32'h8);
    edge_in(); req_valid = '0; req_last = '0;
    sample();  check("to_r3_data", 32'(tx_data), 32'h33);
`else
    for (int c = 18; c <= 21; c++) begin
      edge_in();
      sample();
      check("noto_grant", 32'(grant), 32'h2);
      check("noto_pulse", 32'(timeout), 0);
    end
    edge_in(); set_req(1, 1'b1, 8'h62, 1'b1);
    sample();  check("noto_ready", 32'(req_ready), 32'h2);
    edge_in(); set_req(1, 1'b0, 8'h00, 1'b0);
    sample();  check("noto_rel_grant", 32'(grant), 0);
               check("noto_rel_data", 32'(tx_data), 32'h62);
    edge_in();
    sample();  check("noto_next_grant", 32'(grant), 32'h8);
    edge_in(); req_valid = '0; req_last = '0;
    sample();  check("noto_r3_data", 32'(tx_data), 32'h33);
`endif

    // Reset mid-transfer: requester 2 streaming, output stage full
    edge_in(); set_req(2, 1'b1, 8'h90, 1'b0);
    edge_in();
    edge_in(); req_data[23:16] = 8'h91;
    sample();  check("mr_pre_txv", 32'(tx_valid), 1);
               check("mr_pre_data", 32'(tx_data), 32'h90);
    #1 rst = 1'b1;
    #1;
    check("mr_txv",     32'(tx_valid),  0);
    check("mr_data",    32'(tx_data),   0);
    check("mr_grant",   32'(grant),     0);
    check("mr_ready",   32'(req_ready), 0);
    check("mr_busy",    32'(busy),      0);
    check("mr_timeout", 32'(timeout),   0);
    edge_in();
    rst = 1'b0;
    req_valid = '0;
    set_req(0, 1'b1, 8'hC0, 1'b1);
    set_req(3, 1'b1, 8'hC3, 1'b1);
    edge_in();
    sample();  check("mr_first_grant", 32'(grant), 32'h1);
    edge_in(); req_valid = '0; req_last = '0;
    sample();  check("mr_first_data", 32'(tx_data), 32'hC0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
